// File: rtl/dma_channel_arbiter_if.sv
// Command, DMA-controller and interrupt signals of the DMA channel arbiter.
// master = CPU/DMA-controller side, slave = arbiter.
interface dma_channel_arbiter_if #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int WORD_SIZE = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CH_W-1:0]      cmd_ch;
    logic [WORD_SIZE-1:0] cmd_addr;
    logic [WORD_SIZE-1:0] cmd_len;
    logic                 cpu_mem_busy;
    logic                 br;
    logic                 bg;
    logic                 begin_dma;
    logic [WORD_SIZE-1:0] target_address;
    logic [WORD_SIZE-1:0] length;
    logic [CH_W-1:0]      dma_ch;
    logic                 dma_done;
    logic [NUM_CH-1:0]    irq_ack;
    logic [NUM_CH-1:0]    irq_status;
    logic                 irq;
    logic                 busy;

    modport master (
        output cmd_valid, cmd_ch, cmd_addr, cmd_len, cpu_mem_busy, br, dma_done, irq_ack,
        input  cmd_ready, bg, begin_dma, target_address, length, dma_ch, irq_status, irq, busy
    );

    modport slave (
        input  cmd_valid, cmd_ch, cmd_addr, cmd_len, cpu_mem_busy, br, dma_done, irq_ack,
        output cmd_ready, bg, begin_dma, target_address, length, dma_ch, irq_status, irq, busy
    );
endinterface

// File: rtl/dma_channel_arbiter.sv
// Multi-channel DMA front end: round-robin issue of posted commands, br/bg
// ownership with bounded-grant cycle stealing, write-1-clear completion flags.
module dma_channel_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int WORD_SIZE = 16,
    parameter int MAX_GRANT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    dma_channel_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_GRANT + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    state_t                             state, state_nx;
    logic [NUM_CH-1:0]                  pending, pending_nx;
    logic [NUM_CH-1:0]                  irq_status, irq_nx;
    logic                               irq_q;
    logic [NUM_CH-1:0][WORD_SIZE-1:0]   ch_addr, ch_len;
    logic [CH_W-1:0]                    rr, sel_ch, dma_ch_q;
    logic                               sel_valid;
    logic [WORD_SIZE-1:0]               addr_q, len_q;
    logic                               bg_q, bg_nx, steal_q, steal_nx;
    logic [CNT_W-1:0]                   grant_cnt, grant_cnt_nx;
    logic                               accept;

    assign accept = bus.cmd_valid && !pending[bus.cmd_ch];

    // Walk downwards so the channel closest to rr is the one that sticks.
    always_comb begin
        sel_valid = 1'b0;
        sel_ch    = rr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[rr + CH_W'(i)]) begin
                sel_valid = 1'b1;
                sel_ch    = rr + CH_W'(i);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sel_valid) state_nx = ISSUE;
            ISSUE:   state_nx = XFER;
            XFER:    if (bus.dma_done) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // After a forced one-cycle drop the CPU has had its slot, so the regrant
    // does not wait for cpu_mem_busy to fall.
    always_comb begin
        bg_nx        = 1'b0;
        steal_nx     = 1'b0;
        grant_cnt_nx = '0;
        if (state == XFER && !bus.dma_done) begin
            if (bg_q) begin
                if (!bus.br) begin
                    bg_nx = 1'b0;
                end else if (MAX_GRANT != 0 && grant_cnt == CNT_W'(MAX_GRANT) && bus.cpu_mem_busy) begin
                    steal_nx = 1'b1;
                end else begin
                    bg_nx        = 1'b1;
                    grant_cnt_nx = (grant_cnt == CNT_W'(MAX_GRANT)) ? grant_cnt : grant_cnt + 1'b1;
                end
            end else if (bus.br && (!bus.cpu_mem_busy || steal_q)) begin
                bg_nx        = 1'b1;
                grant_cnt_nx = CNT_W'(1);
            end
        end
    end

    always_comb begin
        pending_nx = pending;
        irq_nx     = irq_status & ~bus.irq_ack;
        if (accept) begin
            if (bus.cmd_len == '0) irq_nx[bus.cmd_ch]     = 1'b1;
            else                   pending_nx[bus.cmd_ch] = 1'b1;
        end
        if (state == DONE) begin
            pending_nx[dma_ch_q] = 1'b0;
            irq_nx[dma_ch_q]     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            irq_status <= '0;
            irq_q      <= 1'b0;
            ch_addr    <= '0;
            ch_len     <= '0;
            rr         <= '0;
            dma_ch_q   <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            bg_q       <= 1'b0;
            steal_q    <= 1'b0;
            grant_cnt  <= '0;
        end else begin
            state      <= state_nx;
            pending    <= pending_nx;
            irq_status <= irq_nx;
            irq_q      <= |irq_nx;
            bg_q       <= bg_nx;
            steal_q    <= steal_nx;
            grant_cnt  <= grant_cnt_nx;
            if (accept) begin
                ch_addr[bus.cmd_ch] <= bus.cmd_addr;
                ch_len[bus.cmd_ch]  <= bus.cmd_len;
            end
            if (state == IDLE && sel_valid) begin
                dma_ch_q <= sel_ch;
                addr_q   <= ch_addr[sel_ch];
                len_q    <= ch_len[sel_ch];
                rr       <= sel_ch + CH_W'(1);
            end
        end
    end

    assign bus.cmd_ready      = !pending[bus.cmd_ch];
    assign bus.bg             = bg_q;
    assign bus.begin_dma      = (state == ISSUE);
    assign bus.target_address = addr_q;
    assign bus.length         = len_q;
    assign bus.dma_ch         = dma_ch_q;
    assign bus.irq_status     = irq_status;
    assign bus.irq            = irq_q;
    assign bus.busy           = (state != IDLE);
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed scenarios followed by a randomized run scored against a
// transaction-level model of channel scheduling, grants and interrupts.
module tb_dma_channel_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    dma_channel_arbiter_if #(.NUM_CH(4), .CH_W(2), .WORD_SIZE(16)) bus ();

    dma_channel_arbiter #(.NUM_CH(4), .CH_W(2), .WORD_SIZE(16), .MAX_GRANT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int ch, input logic [15:0] a, input logic [15:0] l);
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = 2'(ch);
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
    endtask

    task automatic wait_issue();
        int n = 0;
        while (bus.begin_dma !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("issue_seen", bus.begin_dma, 1);
    endtask

    // Waits for the next issue, checks its fields, then completes it.
    task automatic expect_issue(input int ch, input logic [15:0] a, input logic [15:0] l);
        wait_issue();
        chk("issue_ch", bus.dma_ch, ch);
        chk("issue_addr", bus.target_address, a);
        chk("issue_len", bus.length, l);
        tick();
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        chk("done_bg", bus.bg, 0);
        tick();
        chk("done_irq_bit", bus.irq_status[ch], 1);
    endtask

    task automatic ack_all();
        bus.irq_ack = 4'hF;
        tick();
        bus.irq_ack = 4'h0;
        chk("ack_clear", bus.irq_status, 0);
    endtask

    // reference model state
    bit [3:0]    m_pend, m_irq, pb, pend_n, irq_n;
    logic [15:0] m_addr [4];
    logic [15:0] m_len  [4];
    int          m_rr, m_act, phase, ph_n, cd, sel;
    bit          acc, bg_n;

    initial begin
        reset            = 1'b1;
        bus.cmd_valid    = 1'b0;
        bus.cmd_ch       = '0;
        bus.cmd_addr     = '0;
        bus.cmd_len      = '0;
        bus.cpu_mem_busy = 1'b0;
        bus.br           = 1'b0;
        bus.dma_done     = 1'b0;
        bus.irq_ack      = '0;
        #3;
        chk("rst_bg", bus.bg, 0);
        chk("rst_begin", bus.begin_dma, 0);
        chk("rst_irq_status", bus.irq_status, 0);
        chk("rst_irq", bus.irq, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_addr", bus.target_address, 0);
        chk("rst_len", bus.length, 0);
        chk("rst_ch", bus.dma_ch, 0);
        tick();
        tick();
        reset = 1'b0;

        // single transfer on ch1
        send(1, 16'h000B, 16'd12);
        #1 chk("st_ready", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("st_no_begin_yet", bus.begin_dma, 0);
        tick();
        chk("st_begin", bus.begin_dma, 1);
        chk("st_addr", bus.target_address, 16'h000B);
        chk("st_len", bus.length, 12);
        chk("st_ch", bus.dma_ch, 1);
        chk("st_busy", bus.busy, 1);
        bus.br = 1'b1;
        tick();
        chk("st_bg_wait", bus.bg, 0);
        tick();
        chk("st_bg_up", bus.bg, 1);
        chk("st_begin_once", bus.begin_dma, 0);
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        bus.br       = 1'b0;
        chk("st_done_bg", bus.bg, 0);
        chk("st_done_addr", bus.target_address, 16'h000B);
        #1 chk("st_done_refuse", bus.cmd_ready, 0);
        tick();
        chk("st_irq_status", bus.irq_status, 4'b0010);
        chk("st_irq", bus.irq, 1);
        chk("st_idle", bus.busy, 0);
        #1 chk("st_after_done_ready", bus.cmd_ready, 1);
        bus.irq_ack = 4'b0010;
        tick();
        bus.irq_ack = 4'b0000;
        chk("st_ack_irq", bus.irq, 0);

        // zero-length command
        send(3, 16'h0033, 16'd0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("zl_irq_status", bus.irq_status, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            chk("zl_no_begin", bus.begin_dma, 0);
            chk("zl_no_busy", bus.busy, 0);
            tick();
        end
        ack_all();

        // refusal to a pending channel
        send(0, 16'h0100, 16'd5);
        tick();
        send(0, 16'h0200, 16'd7);
        #1 chk("rf_refuse", bus.cmd_ready, 0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("rf_begin", bus.begin_dma, 1);
        chk("rf_addr", bus.target_address, 16'h0100);
        chk("rf_len", bus.length, 5);
        tick();
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        tick();
        chk("rf_irq", bus.irq_status, 4'b0001);
        ack_all();

        // round robin: ch0 and ch3 posted while ch2 is active
        send(2, 16'h02A2, 16'd22);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("rr_first", bus.dma_ch, 2);
        chk("rr_first_begin", bus.begin_dma, 1);
        send(0, 16'h00A0, 16'd10);
        tick();
        send(3, 16'h03A3, 16'd33);
        tick();
        bus.cmd_valid = 1'b0;
        bus.dma_done  = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        tick();
        expect_issue(3, 16'h03A3, 16'd33);
        expect_issue(0, 16'h00A0, 16'd10);
        ack_all();

        // cycle stealing: 8 high, 1 low while CPU keeps needing the bus
        send(1, 16'h0111, 16'd4);
        tick();
        bus.cmd_valid = 1'b0;
        wait_issue();
        tick();
        bus.br = 1'b1;
        tick();
        bus.cpu_mem_busy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("steal_pattern", bus.bg, (k % 9) != 8);
            tick();
        end
        bus.cpu_mem_busy = 1'b0;
        tick();
        for (int k = 0; k < 20; k++) begin
            chk("steal_free_bg", bus.bg, 1);
            tick();
        end
        bus.br = 1'b0;
        tick();
        chk("steal_br_drop", bus.bg, 0);
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        tick();
        ack_all();

        // ack in the same cycle the completion flag is set
        send(1, 16'h01B1, 16'd3);
        tick();
        bus.cmd_valid = 1'b0;
        wait_issue();
        tick();
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        bus.irq_ack  = 4'b0010;
        chk("race_pre", bus.irq_status, 0);
        tick();
        bus.irq_ack = 4'b0000;
        chk("race_set_wins", bus.irq_status, 4'b0010);
        ack_all();

        // reset while bg is high
        send(0, 16'h0000, 16'd0);
        tick();
        send(2, 16'h0222, 16'd9);
        chk("ab_irq_pre", bus.irq_status, 4'b0001);
        tick();
        bus.cmd_valid = 1'b0;
        wait_issue();
        tick();
        bus.br = 1'b1;
        send(3, 16'h0333, 16'd5);
        tick();
        bus.cmd_valid = 1'b0;
        chk("ab_bg_up", bus.bg, 1);
        reset = 1'b1;
        #1;
        chk("ab_bg", bus.bg, 0);
        chk("ab_busy", bus.busy, 0);
        chk("ab_irq_status", bus.irq_status, 0);
        chk("ab_irq", bus.irq, 0);
        chk("ab_ch", bus.dma_ch, 0);
        chk("ab_addr", bus.target_address, 0);
        bus.cmd_ch = 2'd3;
        #1 chk("ab_pend_cleared", bus.cmd_ready, 1);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ab_no_begin", bus.begin_dma, 0);
            chk("ab_no_bg", bus.bg, 0);
        end
        bus.br = 1'b0;

        // randomized run against the model
        m_pend = '0;
        m_irq  = '0;
        m_rr   = 0;
        m_act  = 0;
        phase  = 0;
        cd     = 0;
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = '0;
            m_len[i]  = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.cmd_valid = ($urandom_range(0, 2) == 0);
            bus.cmd_ch    = 2'($urandom_range(0, 3));
            bus.cmd_addr  = 16'($urandom);
            bus.cmd_len   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 200));
            bus.irq_ack   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            bus.br        = 1'($urandom);
            if (phase == 2) begin
                bus.dma_done = (cd == 0);
                if (cd > 0) cd--;
            end else begin
                bus.dma_done = ($urandom_range(0, 7) == 0);
            end
            #1;
            chk("rnd_cmd_ready", bus.cmd_ready, !m_pend[bus.cmd_ch]);

            acc    = bus.cmd_valid && !m_pend[bus.cmd_ch];
            pb     = m_pend;
            pend_n = m_pend;
            irq_n  = m_irq & ~bus.irq_ack;
            if (acc) begin
                m_addr[bus.cmd_ch] = bus.cmd_addr;
                m_len[bus.cmd_ch]  = bus.cmd_len;
                if (bus.cmd_len == 0) irq_n[bus.cmd_ch]  = 1'b1;
                else                  pend_n[bus.cmd_ch] = 1'b1;
            end
            if (phase == 3) begin
                pend_n[m_act] = 1'b0;
                irq_n[m_act]  = 1'b1;
            end
            bg_n = (phase == 2) && !bus.dma_done && bus.br;
            ph_n = phase;
            case (phase)
                0: begin
                    sel = -1;
                    for (int i = 0; i < 4; i++)
                        if (sel < 0 && pb[(m_rr + i) % 4]) sel = (m_rr + i) % 4;
                    if (sel >= 0) begin
                        m_act = sel;
                        m_rr  = (sel + 1) % 4;
                        ph_n  = 1;
                    end
                end
                1: begin
                    ph_n = 2;
                    cd   = $urandom_range(0, 5);
                end
                2: if (bus.dma_done) ph_n = 3;
                default: ph_n = 0;
            endcase

            tick();
            m_pend = pend_n;
            m_irq  = irq_n;
            phase  = ph_n;
            chk("rnd_bg", bus.bg, bg_n);
            chk("rnd_irq_status", bus.irq_status, irq_n);
            chk("rnd_irq", bus.irq, |irq_n);
            chk("rnd_busy", bus.busy, ph_n != 0);
            chk("rnd_begin", bus.begin_dma, ph_n == 1);
            if (ph_n != 0) begin
                chk("rnd_ch", bus.dma_ch, m_act);
                chk("rnd_addr", bus.target_address, m_addr[m_act]);
                chk("rnd_len", bus.length, m_len[m_act]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
